// File: rtl/washer_pkg.sv
// Shared panel state, run-state, mode and water-level definitions for the washer
// front panel and program timer.
package washer_pkg;

  localparam int unsigned RS_W    = 2;
  localparam int unsigned MODE_W  = 3;
  localparam int unsigned WATER_W = 3;
  localparam int unsigned SEC_W   = 8;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } panel_state_e;

  localparam logic [RS_W-1:0] RS_IDLE  = 2'b00;
  localparam logic [RS_W-1:0] RS_RUN   = 2'b01;
  localparam logic [RS_W-1:0] RS_PAUSE = 2'b10;

  localparam logic [MODE_W-1:0] MODE_WASH_RINSE_SPIN = 3'd0;
  localparam logic [MODE_W-1:0] MODE_WASH            = 3'd1;
  localparam logic [MODE_W-1:0] MODE_WASH_RINSE      = 3'd2;
  localparam logic [MODE_W-1:0] MODE_RINSE           = 3'd3;
  localparam logic [MODE_W-1:0] MODE_RINSE_SPIN      = 3'd4;
  localparam logic [MODE_W-1:0] MODE_SPIN            = 3'd5;
  localparam logic [MODE_W-1:0] MODE_MAX             = MODE_SPIN;

  localparam logic [WATER_W-1:0] WATER_MIN = 3'd1;
  localparam logic [WATER_W-1:0] WATER_MAX = 3'd5;
  localparam logic [WATER_W-1:0] WATER_DEF = 3'd2;

  function automatic logic [MODE_W-1:0] mode_next(input logic [MODE_W-1:0] m);
    return (m >= MODE_MAX) ? MODE_WASH_RINSE_SPIN : m + MODE_W'(1);
  endfunction

  function automatic logic [WATER_W-1:0] water_next(input logic [WATER_W-1:0] w);
    return (w >= WATER_MAX) ? WATER_MIN : w + WATER_W'(1);
  endfunction

  function automatic logic [RS_W-1:0] run_state_of(input panel_state_e s);
    case (s)
      ST_RUN, ST_DONE: return RS_RUN;
      ST_PAUSE:        return RS_PAUSE;
      default:         return RS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick generator: counts 0..CLK_HZ-1 while enabled and flags the last
// count. Held at zero when disabled or cleared.
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || !en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/washer_panel_ctrl.sv
// Washer front panel: key presses -> power, run state, mode and water level, with
// idle and completion auto power-off. Define WASHER_BEEP_EN for the DONE beeper.
module washer_panel_ctrl
  import washer_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned IDLE_SEC = 60,
  parameter int unsigned DONE_SEC = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power_btn,
  input  logic               start_btn,
  input  logic               mode_btn,
  input  logic               water_btn,
  input  logic               finish,
  output logic               power_light,
  output logic [RS_W-1:0]    run_state,
  output logic [MODE_W-1:0]  current_model,
  output logic [WATER_W-1:0] current_water,
  output logic               beep
);

  localparam logic [SEC_W-1:0] IDLE_LIM = SEC_W'(IDLE_SEC);
  localparam logic [SEC_W-1:0] DONE_LIM = SEC_W'(DONE_SEC);

  panel_state_e       r_state, w_state_next;
  logic [3:0]         r_btn_q;
  logic               r_finish_q;
  logic [MODE_W-1:0]  r_model, w_model_next;
  logic [WATER_W-1:0] r_water, w_water_next;
  logic [SEC_W-1:0]   r_sec;
  logic               r_power_light;
  logic [RS_W-1:0]    r_run_state;
  logic [MODE_W-1:0]  r_model_out;
  logic [WATER_W-1:0] r_water_out;

  logic [3:0]       w_btn, w_press;
  logic             w_pwr, w_start, w_mode, w_water;
  logic             w_finish_rise, w_idle_press, w_cnt_clr;
  logic             w_tick, w_tick_en, w_idle_timeout, w_done_timeout;
  logic [SEC_W-1:0] w_sec_inc;

  assign w_btn         = {power_btn, start_btn, mode_btn, water_btn};
  assign w_press       = w_btn & ~r_btn_q;
  assign w_pwr         = w_press[3];
  assign w_start       = w_press[2];
  assign w_mode        = w_press[1];
  assign w_water       = w_press[0];
  assign w_finish_rise = finish & ~r_finish_q;

  assign w_tick_en      = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_sec_inc      = (r_sec == '1) ? r_sec : r_sec + SEC_W'(1);
  // Timeout fires on the tick that makes the seconds count reach the limit.
  assign w_idle_timeout = w_tick && (w_sec_inc >= IDLE_LIM);
  assign w_done_timeout = w_tick && (w_sec_inc >= DONE_LIM);
  assign w_cnt_clr      = w_idle_press || (w_state_next != r_state);

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk (clk),
    .rst (rst),
    .clr (w_cnt_clr),
    .en  (w_tick_en),
    .tick(w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_model    <= MODE_WASH_RINSE_SPIN;
      r_water    <= WATER_DEF;
      r_btn_q    <= '0;
      r_finish_q <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_model    <= w_model_next;
      r_water    <= w_water_next;
      r_btn_q    <= w_btn;
      r_finish_q <= finish;
    end
  end

  // Only the highest-priority press acts: power > start > mode > water.
  always_comb begin
    w_state_next = r_state;
    w_model_next = r_model;
    w_water_next = r_water;
    w_idle_press = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (w_pwr) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_pwr) begin
          w_state_next = ST_OFF;
        end else if (w_start) begin
          w_state_next = ST_RUN;
          w_idle_press = 1'b1;
        end else if (w_mode) begin
          w_model_next = mode_next(r_model);
          w_idle_press = 1'b1;
        end else if (w_water) begin
          w_water_next = water_next(r_water);
          w_idle_press = 1'b1;
        end else if (w_idle_timeout) begin
          w_state_next = ST_OFF;
        end
      end
      ST_RUN: begin
        if (w_pwr)              w_state_next = ST_OFF;
        else if (w_start)       w_state_next = ST_PAUSE;
        else if (w_finish_rise) w_state_next = ST_DONE;
      end
      ST_PAUSE: begin
        if (w_pwr)        w_state_next = ST_OFF;
        else if (w_start) w_state_next = ST_RUN;
      end
      ST_DONE: begin
        if (w_pwr || w_done_timeout) w_state_next = ST_OFF;
      end
      default: w_state_next = ST_OFF;
    endcase
    if ((w_state_next == ST_OFF) && (r_state != ST_OFF)) begin
      w_model_next = MODE_WASH_RINSE_SPIN;
      w_water_next = WATER_DEF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec <= '0;
    end else if (w_cnt_clr || !w_tick_en) begin
      r_sec <= '0;
    end else if (w_tick) begin
      r_sec <= w_sec_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_power_light <= 1'b0;
      r_run_state   <= RS_IDLE;
      r_model_out   <= MODE_WASH_RINSE_SPIN;
      r_water_out   <= WATER_DEF;
    end else begin
      r_power_light <= (r_state != ST_OFF);
      r_run_state   <= run_state_of(r_state);
      r_model_out   <= r_model;
      r_water_out   <= r_water;
    end
  end

  assign power_light   = r_power_light;
  assign run_state     = r_run_state;
  assign current_model = r_model_out;
  assign current_water = r_water_out;

`ifdef WASHER_BEEP_EN
  logic r_beep;

  // Beep on even seconds of DONE, aligned with the registered run_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_beep <= 1'b0;
    else     r_beep <= (r_state == ST_DONE) && !r_sec[0];
  end

  assign beep = r_beep;
`else
  assign beep = 1'b0;
`endif

endmodule
